// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: load-use stall, I/D-memory wait, branch flush and halt.
// Optional stall-cycle counter is built when HAZARD_PERF_EN is defined.
module hazard_control_unit
`ifdef HAZARD_PERF_EN
    #(parameter int unsigned PERF_W = 32)
`endif
    (
    input  logic       CLK,
    input  logic       nRST,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rt,
    input  logic [4:0] ex_rd,
    input  logic       ex_memRd,
    input  logic       ihit,
    input  logic       mem_dreq,
    input  logic       dhit,
    input  logic       mem_pcsrc,
    input  logic       mem_halt,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       idex_en,
    output logic       exmem_en,
    output logic       memwb_en,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       exmem_flush,
    output logic       halted
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   dstall;
    logic   load_use;

    assign dstall   = mem_dreq && !dhit;
    assign load_use = ex_memRd && (ex_rd != '0) &&
                      ((ex_rd == id_rs) || (id_use_rt && (ex_rd == id_rt)));

    // Priority chain: reset, halted, halt, data wait, then the RUN decode
    // (DWAIT with dhit=1 falls through to the RUN decode).
    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        halted      = 1'b0;
        state_d     = state_q;
        if (!nRST) begin
            state_d = RUN;
        end else if (state_q == HALTED) begin
            halted = 1'b1;
        end else if (mem_halt && !dstall) begin
            memwb_en    = 1'b1;
            exmem_flush = 1'b1;
            state_d     = HALTED;
        end else if (dstall) begin
            state_d = DWAIT;
        end else begin
            state_d  = RUN;
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            if (mem_pcsrc) begin
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
            end else if (load_use) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end else if (!ihit) begin
                pc_en      = 1'b0;
                ifid_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] stall_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_q <= '0;
        end else if (!pc_en && (state_q != HALTED) && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed, table-driven bench for hazard_control_unit plus hand-written
// multi-cycle sequences (data wait, halt, async reset).
module tb_hazard_control_unit;

    logic       CLK = 1'b0;
    logic       nRST;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       id_use_rt, ex_memRd, ihit, mem_dreq, dhit, mem_pcsrc, mem_halt;
    logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic       ifid_flush, idex_flush, exmem_flush, halted;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt;
`endif

    int nchecks = 0;
    int nerrors = 0;

    always #5 CLK = ~CLK;

    hazard_control_unit dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_use_rt  (id_use_rt),
        .ex_rd      (ex_rd),
        .ex_memRd   (ex_memRd),
        .ihit       (ihit),
        .mem_dreq   (mem_dreq),
        .dhit       (dhit),
        .mem_pcsrc  (mem_pcsrc),
        .mem_halt   (mem_halt),
        .pc_en      (pc_en),
        .ifid_en    (ifid_en),
        .idex_en    (idex_en),
        .exmem_en   (exmem_en),
        .memwb_en   (memwb_en),
        .ifid_flush (ifid_flush),
        .idex_flush (idex_flush),
        .exmem_flush(exmem_flush),
        .halted     (halted)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    // {pc, ifid, idex, exmem, memwb, ifid_fl, idex_fl, exmem_fl, halted}
    logic [8:0] outs;
    assign outs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                   ifid_flush, idex_flush, exmem_flush, halted};

    localparam logic [8:0] ZERO  = 9'b00000_000_0;
    localparam logic [8:0] EN    = 9'b11111_000_0;
    localparam logic [8:0] LDUSE = 9'b00111_010_0;
    localparam logic [8:0] IMISS = 9'b01111_100_0;
    localparam logic [8:0] BR    = 9'b11111_111_0;
    localparam logic [8:0] HALT  = 9'b00001_001_0;
    localparam logic [8:0] HLTD  = 9'b00000_000_1;

    typedef struct {
        string      name;
        logic [4:0] rs, rt, rd;
        logic       use_rt, memrd, ih, dreq, dh, pcsrc, hlt;
        logic [8:0] exp;
    } vec_t;

    function automatic vec_t mk(string nm, logic [4:0] rs, logic [4:0] rt, logic use_rt,
                                logic [4:0] rd, logic memrd, logic ih, logic dreq,
                                logic dh, logic pcsrc, logic hlt, logic [8:0] exp);
        vec_t v;
        v.name = nm; v.rs = rs; v.rt = rt; v.use_rt = use_rt; v.rd = rd;
        v.memrd = memrd; v.ih = ih; v.dreq = dreq; v.dh = dh; v.pcsrc = pcsrc;
        v.hlt = hlt; v.exp = exp;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        id_rs = v.rs; id_rt = v.rt; id_use_rt = v.use_rt; ex_rd = v.rd;
        ex_memRd = v.memrd; ihit = v.ih; mem_dreq = v.dreq; dhit = v.dh;
        mem_pcsrc = v.pcsrc; mem_halt = v.hlt;
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrors++;
            $display("FAIL %s: got %b expected %b", nm, got, exp);
        end
    endtask

    task automatic step(input vec_t v);
        @(posedge CLK);
        #1;
        drive(v);
        @(negedge CLK);
        check(v.name, {23'd0, outs}, {23'd0, v.exp});
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        nRST = 1'b0;
        drive(mk("idle", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, EN));
        #2;
        nRST = 1'b1;
    endtask

    vec_t tbl[15];

    initial begin
        tbl[0]  = mk("idle",            0, 0, 0, 0, 0, 1, 0, 0, 0, 0, EN);
        tbl[1]  = mk("loaduse_rs",      5, 2, 0, 5, 1, 1, 0, 0, 0, 0, LDUSE);
        tbl[2]  = mk("loaduse_rt",      3, 7, 1, 7, 1, 1, 0, 0, 0, 0, LDUSE);
        tbl[3]  = mk("rt_not_used",     3, 5, 0, 5, 1, 1, 0, 0, 0, 0, EN);
        tbl[4]  = mk("zero_reg",        0, 0, 1, 0, 1, 1, 0, 0, 0, 0, EN);
        tbl[5]  = mk("match_no_load",   5, 5, 1, 5, 0, 1, 0, 0, 0, 0, EN);
        tbl[6]  = mk("imiss",           0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IMISS);
        tbl[7]  = mk("branch",          0, 0, 0, 0, 0, 1, 0, 0, 1, 0, BR);
        tbl[8]  = mk("branch_vs_lu",    5, 0, 0, 5, 1, 0, 0, 0, 1, 0, BR);
        tbl[9]  = mk("lu_vs_imiss",     5, 0, 0, 5, 1, 0, 0, 0, 0, 0, LDUSE);
        tbl[10] = mk("dreq_hit",        0, 0, 0, 0, 0, 1, 1, 1, 0, 0, EN);
        tbl[11] = mk("dreq_miss",       0, 0, 0, 0, 0, 1, 1, 0, 0, 0, ZERO);
        tbl[12] = mk("dwait_nodreq",    0, 0, 0, 0, 0, 1, 0, 0, 0, 0, EN);
        tbl[13] = mk("dmiss_branch",    0, 0, 0, 0, 0, 1, 1, 0, 1, 0, ZERO);
        tbl[14] = mk("dhit_branch",     0, 0, 0, 0, 0, 1, 1, 1, 1, 0, BR);

        nRST = 1'b0;
        drive(tbl[0]);
        #3;
        check("reset_outs", {23'd0, outs}, 32'd0);
`ifdef HAZARD_PERF_EN
        check("reset_cnt", stall_cnt, 32'd0);
`endif
        @(posedge CLK);
        #1;
        nRST = 1'b1;

        for (int i = 0; i < 15; i++) step(tbl[i]);

        // load-use lasts exactly one cycle once the load leaves EX
        step(mk("lu_cycle",   5, 0, 0, 5, 1, 1, 0, 0, 0, 0, LDUSE));
        step(mk("lu_release", 5, 0, 0, 5, 0, 1, 0, 0, 0, 0, EN));

        do_reset();
        for (int i = 0; i < 4; i++) step(mk("dwait_freeze", 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, ZERO));
        step(mk("dwait_hit",  0, 0, 0, 0, 0, 1, 1, 1, 0, 0, EN));
        step(mk("dwait_run",  0, 0, 0, 0, 0, 1, 0, 0, 0, 0, EN));
`ifdef HAZARD_PERF_EN
        check("dwait_cnt", stall_cnt, 32'd4);
`endif

        do_reset();
        step(mk("halt_in_dmiss", 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, ZERO));
        step(mk("halt",          0, 0, 0, 0, 0, 1, 0, 0, 0, 1, HALT));
        for (int i = 0; i < 10; i++)
            step(mk("halted_hold", 0, 0, 0, 0, 0, 1'(i % 2), 0, 0, 1'(i % 3 == 0), 0, HLTD));
`ifdef HAZARD_PERF_EN
        check("halt_cnt", stall_cnt, 32'd2);
`endif
        do_reset();
        step(mk("after_halt_rst", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, EN));

        // async reset while in DWAIT: outputs must drop without a clock edge
        step(mk("pre_async_miss", 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, ZERO));
        @(posedge CLK);
        #1;
        drive(mk("dwait_hit", 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, EN));
        #1;
        check("dwait_hit_pre", {23'd0, outs}, {23'd0, EN});
        nRST = 1'b0;
        #1;
        check("async_rst_outs", {23'd0, outs}, 32'd0);
`ifdef HAZARD_PERF_EN
        check("async_rst_cnt", stall_cnt, 32'd0);
`endif
        #1;
        nRST = 1'b1;
        drive(mk("idle", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, EN));
        @(negedge CLK);
        check("post_async_run", {23'd0, outs}, {23'd0, EN});
        step(mk("post_async_imiss", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IMISS));

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
